ram_test_sequencer: RTL and testbench

RAM_TEST_SEQUENCER -- requirements
Module: ram_test_sequencer

---
 rtl/ram_test_pkg.sv | 8 +
 rtl/ram_test_pattern_gen.sv | 22 ++
 rtl/ram_test_sequencer.sv | 88 ++++++++
 tb/tb_ram_test_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// ram_test_pkg: shared FSM state encoding and pattern code constants
package ram_test_pkg;
  typedef enum logic [2:0] {s_idle, s_write, s_read, s_drain, s_done} state_t;
  localparam logic [1:0] pat_addr = 2'd0;
  localparam logic [1:0] pat_inv = 2'd1;
  localparam logic [1:0] pat_check = 2'd2;
  localparam logic [1:0] pat_stripe = 2'd3;
endpackage

// File: rtl/ram_test_pattern_gen.sv
// ram_test_pattern_gen: combinational test word for an address and pattern code
module ram_test_pattern_gen import ram_test_pkg::*; #(
  parameter int BITWIDTH_IN = 12,
  parameter int BITWIDTH_SYS = 16,
  parameter int BITWIDTH_ADR = 6
) (
  input logic [BITWIDTH_ADR-1:0] adr,
  input logic [1:0] code,
  output logic [BITWIDTH_SYS-1:0] word
);
  localparam int sh = BITWIDTH_SYS - BITWIDTH_IN;
  localparam logic [BITWIDTH_SYS-1:0] msk = {BITWIDTH_SYS{1'b1}} << sh;
  localparam logic [BITWIDTH_SYS-1:0] alt = BITWIDTH_SYS'({BITWIDTH_SYS{2'b10}});
  logic [BITWIDTH_SYS-1:0] w0;
  always_comb begin
    w0 = BITWIDTH_SYS'(BITWIDTH_IN'(adr)) << sh;
    word = code == pat_addr ? w0 :
           code == pat_inv ? ~w0 & msk :
           code == pat_check ? (adr[0] ? ~alt : alt) & msk :
           adr[0] ? '0 : msk;
  end
endmodule

// File: rtl/ram_test_sequencer.sv
// ram_test_sequencer: writes a pattern to a RAM, reads it back and counts mismatches
module ram_test_sequencer import ram_test_pkg::*; #(
  parameter int BITWIDTH_IN = 12,
  parameter int BITWIDTH_SYS = 16,
  parameter int BITWIDTH_ADR = 6
) (
  input logic CLK_SYS,
  input logic RSTN,
  input logic START,
  input logic [1:0] PATTERN,
  output logic RAM_EN,
  output logic RAM_TRGG,
  output logic RAM_RNW,
  output logic [BITWIDTH_ADR-1:0] RAM_ADR,
  output logic [BITWIDTH_SYS-1:0] RAM_DIN,
  input logic [BITWIDTH_SYS-1:0] RAM_DOUT,
  input logic RAM_RDY,
  output logic BUSY,
  output logic DONE,
  output logic [BITWIDTH_ADR:0] ERR_CNT,
  output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR,
  output logic ERR_FLAG
);
  localparam logic [BITWIDTH_SYS-1:0] msk = {BITWIDTH_SYS{1'b1}} << (BITWIDTH_SYS - BITWIDTH_IN);
  state_t st, st_nx;
  logic [BITWIDTH_ADR-1:0] a, exp_adr;
  logic [BITWIDTH_SYS-1:0] pat, exp_w;
  logic [1:0] code;
  logic rv, go, wr, rd, mis;
  ram_test_pattern_gen #(
    .BITWIDTH_IN(BITWIDTH_IN),
    .BITWIDTH_SYS(BITWIDTH_SYS),
    .BITWIDTH_ADR(BITWIDTH_ADR)
  ) u_pat (
    .adr(a),
    .code(code),
    .word(pat)
  );
  always_ff @(posedge CLK_SYS)
    st <= RSTN ? st_nx : s_idle;
  always_comb begin
    go = START && (st == s_idle || st == s_done);
    wr = st == s_write && RAM_RDY;
    rd = st == s_read && RAM_RDY;
    mis = rv && |((RAM_DOUT ^ exp_w) & msk);
    st_nx = go ? s_write :
            (wr && &a) ? s_read :
            (rd && &a) ? s_drain :
            st == s_drain ? s_done : st;
    RAM_EN = wr || rd;
    RAM_TRGG = wr;
    RAM_RNW = wr;
    RAM_ADR = a;
    RAM_DIN = wr ? pat : '0;
    BUSY = st == s_write || st == s_read || st == s_drain;
    DONE = st == s_done;
  end
  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      a <= '0;
      code <= '0;
      rv <= 1'b0;
      exp_w <= '0;
      exp_adr <= '0;
      ERR_CNT <= '0;
      FIRST_ERR_ADR <= '0;
      ERR_FLAG <= 1'b0;
    end else begin
      rv <= rd;
      exp_w <= pat;
      exp_adr <= a;
      if (go) begin
        a <= '0;
        code <= PATTERN;
        ERR_CNT <= '0;
        FIRST_ERR_ADR <= '0;
        ERR_FLAG <= 1'b0;
      end else begin
        if (wr || rd) a <= a + 1'b1;
        if (mis) begin
          ERR_CNT <= &ERR_CNT ? ERR_CNT : ERR_CNT + 1'b1;
          ERR_FLAG <= 1'b1;
          if (!ERR_FLAG) FIRST_ERR_ADR <= exp_adr;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_test_sequencer.sv
// tb_ram_test_sequencer: randomized scoreboard bench with a 1-cycle RAM model
module tb_ram_test_sequencer;
  localparam int bi = 12, bs = 16, ba = 6, n = 64;
  logic CLK_SYS = 0, RSTN = 0, START = 0, RAM_RDY = 1;
  logic [1:0] PATTERN = 0;
  logic RAM_EN, RAM_TRGG, RAM_RNW, BUSY, DONE, ERR_FLAG;
  logic [ba-1:0] RAM_ADR, FIRST_ERR_ADR;
  logic [bs-1:0] RAM_DIN;
  logic [bs-1:0] RAM_DOUT = '0;
  logic [ba:0] ERR_CNT;
  typedef struct {int c0; int lat; int err; int first; logic [1:0] pat;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [bs-1:0] mem [n];
  logic [bs-1:0] corrupt [n];
  bit rdy [400];
  int cyc = 0, vec = 0, miscmp = 0, wn = 0, rn = 0, done_cnt = 0;
  logic done_q = 0;
  ram_test_sequencer #(.BITWIDTH_IN(bi), .BITWIDTH_SYS(bs), .BITWIDTH_ADR(ba)) dut (
    .CLK_SYS(CLK_SYS), .RSTN(RSTN), .START(START), .PATTERN(PATTERN),
    .RAM_EN(RAM_EN), .RAM_TRGG(RAM_TRGG), .RAM_RNW(RAM_RNW), .RAM_ADR(RAM_ADR),
    .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT), .RAM_RDY(RAM_RDY), .BUSY(BUSY),
    .DONE(DONE), .ERR_CNT(ERR_CNT), .FIRST_ERR_ADR(FIRST_ERR_ADR), .ERR_FLAG(ERR_FLAG)
  );
  always #5 CLK_SYS = ~CLK_SYS;
  always @(posedge CLK_SYS) cyc <= cyc + 1;
  always @(posedge CLK_SYS) begin
    if (RAM_EN && RAM_TRGG) mem[RAM_ADR] <= RAM_DIN;
    if (RAM_EN && !RAM_RNW) RAM_DOUT <= mem[RAM_ADR] ^ corrupt[RAM_ADR];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] ref_pat(input int a, input logic [1:0] p);
    case (p)
      2'd0: return 16'(a * 16);
      2'd1: return 16'((4095 - a) * 16);
      2'd2: return (a % 2 == 0) ? 16'hAAA0 : 16'h5550;
      default: return (a % 2 == 0) ? 16'hFFF0 : 16'h0000;
    endcase
  endfunction
  always @(negedge CLK_SYS) begin
    if (!RSTN) begin
      wn = 0;
      rn = 0;
    end else begin
      chk("trgg", RAM_TRGG, RAM_EN && RAM_RNW);
      if (!BUSY) chk("en_idle", {RAM_EN, RAM_RNW}, 0);
      if (RAM_EN && RAM_RNW) begin
        chk("wr_adr", RAM_ADR, wn);
        if (q.size() > 0) chk("wr_data", RAM_DIN, ref_pat(int'(RAM_ADR), q[0].pat));
        wn++;
      end
      if (RAM_EN && !RAM_RNW) begin
        chk("rd_adr", RAM_ADR, rn);
        rn++;
      end
      if (DONE && !done_q) begin
        if (q.size() == 0) begin
          vec++;
          miscmp++;
          $display("FAIL done_unexpected: got DONE with no run pending at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc - e.c0, e.lat);
          chk("err_cnt", ERR_CNT, e.err);
          chk("first_err_adr", FIRST_ERR_ADR, e.first);
          chk("err_flag", ERR_FLAG, e.err > 0);
          chk("write_count", wn, n);
          chk("read_count", rn, n);
        end
        wn = 0;
        rn = 0;
        done_cnt++;
      end
    end
    done_q = DONE;
  end
  task automatic chk_reset(input string nm);
    chk({nm, "_status"}, {BUSY, DONE, ERR_CNT, FIRST_ERR_ADR, ERR_FLAG}, 0);
    chk({nm, "_ram"}, {RAM_EN, RAM_TRGG, RAM_RNW, RAM_ADR, RAM_DIN}, 0);
  endtask
  task automatic run(input logic [1:0] p, input int start_off, input int rst_off);
    exp_t x;
    int iss = 0;
    int d0;
    x.lat = 0;
    x.err = 0;
    x.first = 0;
    x.pat = p;
    for (int t = 1; t < 400; t++)
      if (iss < 2 * n && rdy[t]) begin
        iss++;
        if (iss == 2 * n) x.lat = t + 2;
      end
    for (int a = n - 1; a >= 0; a--)
      if ((corrupt[a] >> (bs - bi)) != 0) begin
        x.err++;
        x.first = a;
      end
    @(posedge CLK_SYS); #1;
    d0 = done_cnt;
    x.c0 = cyc;
    q.push_back(x);
    START = 1;
    PATTERN = p;
    RAM_RDY = rdy[0];
    for (int t = 1; t < 400 && done_cnt == d0; t++) begin
      @(posedge CLK_SYS); #1;
      START = (t == start_off);
      PATTERN = 2'($urandom);
      RAM_RDY = rdy[t];
      RSTN = (t != rst_off);
      if (t == 1) chk("start_busy_done", {BUSY, DONE}, 2'b10);
      if (rst_off > 0 && t == rst_off + 1) begin
        @(negedge CLK_SYS);
        chk_reset("mid_reset");
        q.delete();
        return;
      end
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask
  task automatic hold_check(input int err);
    repeat (3) @(posedge CLK_SYS);
    @(negedge CLK_SYS);
    chk("done_hold", DONE, 1);
    chk("hold_err_cnt", ERR_CNT, err);
  endtask
  initial begin
    for (int a = 0; a < n; a++) corrupt[a] = '0;
    for (int t = 0; t < 400; t++) rdy[t] = 1;
    repeat (3) @(posedge CLK_SYS);
    @(negedge CLK_SYS);
    chk_reset("reset");
    @(posedge CLK_SYS); #1;
    RSTN = 1;
    run(2'd0, 0, 0);
    hold_check(0);
    corrupt[5] = 16'h8000;
    corrupt[9] = 16'h8000;
    run(2'd1, 0, 0);
    hold_check(2);
    for (int a = 0; a < n; a++) corrupt[a] = 16'($urandom_range(1, 15));
    run(2'($urandom), 0, 0);
    hold_check(0);
    for (int a = 0; a < n; a++) corrupt[a] = '0;
    for (int t = 11; t <= 13; t++) rdy[t] = 0;
    rdy[88] = 0;
    rdy[89] = 0;
    run(2'd0, 0, 0);
    for (int t = 0; t < 400; t++) rdy[t] = 1;
    run(2'd3, 0, 31);
    repeat (3) @(posedge CLK_SYS);
    @(negedge CLK_SYS);
    chk("idle_after_reset", {BUSY, DONE}, 0);
    run(2'd2, 0, 0);
    run(2'd0, 72, 0);
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < n; a++) corrupt[a] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
      for (int t = 0; t < 400; t++) rdy[t] = $urandom_range(0, 99) >= 15;
      run(2'($urandom), 0, 0);
    end
    repeat (2) @(posedge CLK_SYS);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
